// File: rtl/pwm_pkg.sv
// Shared PWM definitions for the 4-channel generator and the capture block.
// Holds the counter width, the stuck timeout, the channel FSM states and the duty saturation helper.
package pwm_pkg;

    localparam int PWM_CNT_W   = 8;
    localparam int PWM_TIMEOUT = 512;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STUCK = 2'd2
    } chan_state_t;

    // Clamp a CNT_W+2 bit high-time count to the CNT_W bit duty range.
    function automatic logic [PWM_CNT_W-1:0] sat_duty(input logic [PWM_CNT_W+1:0] cnt);
        return (cnt[PWM_CNT_W+1:PWM_CNT_W] != 2'b00) ? {PWM_CNT_W{1'b1}} : cnt[PWM_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_capture_chan.sv
// One PWM capture channel: 2-flop sync, optional glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN), counters, FSM, result regs.
// Latency: input edge -> 2 clk sync + 1 tick edge register; valid 1 clk after the publishing tick.
// No backpressure: results overwrite, valid is a single-cycle strobe only on clk_en ticks.
module pwm_capture_chan
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int TIMEOUT = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic             valid,
    output logic             stuck,
    output logic             period_err
);

    localparam int             CW      = CNT_W + 2;
    localparam logic [CW-1:0]  TO      = CW'(TIMEOUT);
    localparam logic [CW-1:0]  NOM     = CW'(2**CNT_W);
    localparam logic [CW-1:0]  CNT_MAX = '1;

    logic          sync1, sync2, s, prev, rise;
    logic [CW-1:0] per_cnt, hi_cnt;
    logic          publish, enter_stuck;
    chan_state_t   state, state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // s follows the sync output only once three consecutive tick samples agree.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      hist <= 2'b00;
        else if (clk_en) hist <= {hist[0], sync2};
    end

    assign s = (sync2 == hist[0] && sync2 == hist[1]) ? sync2 : prev;
`else
    assign s = sync2;
`endif

    assign rise = clk_en & s & ~prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev    <= 1'b0;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (clk_en) begin
            prev <= s;
            if (rise) begin
                per_cnt <= CW'(1);
                hi_cnt  <= CW'(1);
            end else begin
                if (per_cnt != TO)           per_cnt <= per_cnt + CW'(1);
                if (s && hi_cnt != CNT_MAX)  hi_cnt  <= hi_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT, ST_RUN: begin
                if (rise)                              state_nxt = ST_RUN;
                else if (clk_en && per_cnt == TO)      state_nxt = ST_STUCK;
            end
            ST_STUCK: if (rise)                        state_nxt = ST_RUN;
            default:                                   state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        publish     = rise && (state == ST_RUN);
        enter_stuck = clk_en && !rise && (state != ST_STUCK) && (per_cnt == TO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty       <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
            period_err <= 1'b0;
        end else begin
            valid <= publish | enter_stuck;
            if (publish) begin
                duty       <= sat_duty(hi_cnt);
                period_err <= (per_cnt != NOM);
                stuck      <= 1'b0;
            end else if (enter_stuck) begin
                duty       <= s ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
                period_err <= 1'b0;
                stuck      <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Four-channel PWM duty-cycle meter; glitch filter enabled by PWM_CAPTURE_GLITCH_FILTER_EN.
// Latency: input edge -> 2 clk + 1 tick to detect, result and valid 1 clk after the publishing tick.
// No backpressure: each channel strobes valid for one clk and results are simply overwritten.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int TIMEOUT = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [3:0]       pwm_in,
    output logic [CNT_W-1:0] duty0,
    output logic [CNT_W-1:0] duty1,
    output logic [CNT_W-1:0] duty2,
    output logic [CNT_W-1:0] duty3,
    output logic [3:0]       valid,
    output logic [3:0]       stuck,
    output logic [3:0]       period_err
);

    logic [CNT_W-1:0] duty_ch [4];

    for (genvar i = 0; i < 4; i++) begin : g_chan
        pwm_capture_chan #(
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .clk_en     (clk_en),
            .pwm_in     (pwm_in[i]),
            .duty       (duty_ch[i]),
            .valid      (valid[i]),
            .stuck      (stuck[i]),
            .period_err (period_err[i])
        );
    end

    assign duty0 = duty_ch[0];
    assign duty1 = duty_ch[1];
    assign duty2 = duty_ch[2];
    assign duty3 = duty_ch[3];

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven PWM patterns plus hand sequences for stuck,
// reset, clk_en gating and glitches; expected publishes are queued per channel and popped on valid.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_en;
    logic [3:0] pwm_in;
    logic [7:0] duty0, duty1, duty2, duty3;
    logic [3:0] valid, stuck, period_err;

    always #5 clk = ~clk;

    pwm_capture dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .pwm_in     (pwm_in),
        .duty0      (duty0),
        .duty1      (duty1),
        .duty2      (duty2),
        .duty3      (duty3),
        .valid      (valid),
        .stuck      (stuck),
        .period_err (period_err)
    );

    typedef struct packed {
        logic [7:0] duty;
        logic       perr;
        logic       stk;
    } exp_t;

    typedef struct packed {
        logic [3:0][9:0] hi;
        logic [3:0][9:0] per;
        logic [3:0][7:0] ed;
        logic [3:0]      ee;
        logic [3:0]      nper;
    } vec_t;

    exp_t sb [4][$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic toggle_en = 1'b0;
    logic en_q;

    function automatic logic [7:0] get_duty(input int c);
        case (c)
            0:       return duty0;
            1:       return duty1;
            2:       return duty2;
            default: return duty3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) en_q <= clk_en;

    // Scoreboard: every valid pulse must match the oldest expectation queued for that channel.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            for (int c = 0; c < 4; c++) begin
                if (valid[c]) begin
                    if (sb[c].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected valid ch%0d: duty=%0h perr=%b stuck=%b, expected no publish",
                                 c, get_duty(c), period_err[c], stuck[c]);
                    end else begin
                        e = sb[c].pop_front();
                        check($sformatf("publish ch%0d {duty,perr,stuck}", c),
                              32'({get_duty(c), period_err[c], stuck[c]}),
                              32'({e.duty, e.perr, e.stk}));
                    end
                end
            end
            if (valid != 4'h0) check("valid while clk_en low", 32'(en_q), 32'd1);
        end
    end

    task automatic step(input logic [3:0] v);
        pwm_in = v;
        clk_en = 1'b1;
        @(posedge clk); #1;
        if (toggle_en) begin
            clk_en = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input logic [3:0] v);
        pwm_in = v;
        clk_en = 1'b1;
        reset  = 1'b0;
        for (int c = 0; c < 4; c++) sb[c].delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drive_period(input int hi, input int per, input int glitch);
        for (int t = 0; t < per; t++) step((t < hi || t == glitch) ? 4'hF : 4'h0);
    endtask

    task automatic push_all(input logic [7:0] d, input logic e, input logic st);
        for (int c = 0; c < 4; c++) sb[c].push_back('{duty: d, perr: e, stk: st});
    endtask

    task automatic close_and_check(input string name);
        repeat (8) step(4'hF);
        for (int c = 0; c < 4; c++)
            check($sformatf("%s ch%0d pending publishes", name, c), 32'(sb[c].size()), 32'd0);
    endtask

    vec_t rows [4];

    initial begin
        int n;

        rows[0] = '{hi: {10'd255, 10'd192, 10'd128, 10'd64}, per: {4{10'd256}},
                    ed: {8'hFF, 8'hC0, 8'h80, 8'h40}, ee: 4'b0000, nper: 4'd3};
        rows[1] = '{hi: {4{10'd280}}, per: {4{10'd300}}, ed: {4{8'hFF}}, ee: 4'b1111, nper: 4'd3};
        rows[2] = '{hi: {4{10'd100}}, per: {4{10'd200}}, ed: {4{8'h64}}, ee: 4'b1111, nper: 4'd3};
        rows[3] = '{hi: {10'd7, 10'd128, 10'd255, 10'd1}, per: {10'd257, 10'd255, 10'd256, 10'd256},
                    ed: {8'h07, 8'h80, 8'hFF, 8'h01}, ee: 4'b1100, nper: 4'd3};

        do_reset(4'h0);
        check("reset outputs", 32'({duty0, duty1, duty2, duty3, valid, stuck, period_err}), 32'd0);

        // Table: steady patterns per channel, each period expected once closed by the next rise.
        for (int r = 0; r < 4; r++) begin
            int         maxlen;
            logic [3:0] v;
            do_reset(4'h0);
            maxlen = 0;
            for (int c = 0; c < 4; c++)
                if (int'(rows[r].per[c]) * int'(rows[r].nper) > maxlen)
                    maxlen = int'(rows[r].per[c]) * int'(rows[r].nper);
            for (int t = 0; t < maxlen + 8; t++) begin
                for (int c = 0; c < 4; c++) begin
                    int p;
                    p = int'(rows[r].per[c]);
                    if (t / p < int'(rows[r].nper)) begin
                        v[c] = (t % p) < int'(rows[r].hi[c]);
                        if (t % p == p - 1)
                            sb[c].push_back('{duty: rows[r].ed[c], perr: rows[r].ee[c], stk: 1'b0});
                    end else begin
                        v[c] = 1'b1;
                    end
                end
                step(v);
            end
            for (int c = 0; c < 4; c++)
                check($sformatf("row%0d ch%0d pending publishes", r, c), 32'(sb[c].size()), 32'd0);
        end

        // Long period saturating, then a short period, without a reset in between.
        do_reset(4'h0);
        repeat (2) begin drive_period(280, 300, -1); push_all(8'hFF, 1'b1, 1'b0); end
        repeat (2) begin drive_period(100, 200, -1); push_all(8'h64, 1'b1, 1'b0); end
        close_and_check("period change");

        // Stuck: ch1 high from reset, others low; single stuck publish each.
        do_reset(4'b0010);
        sb[0].push_back('{duty: 8'h00, perr: 1'b0, stk: 1'b1});
        sb[1].push_back('{duty: 8'hFF, perr: 1'b0, stk: 1'b1});
        sb[2].push_back('{duty: 8'h00, perr: 1'b0, stk: 1'b1});
        sb[3].push_back('{duty: 8'h00, perr: 1'b0, stk: 1'b1});
        n = 0;
        for (int i = 1; i <= 700; i++) begin
            step(4'b0010);
            if (valid[0]) begin n = i; break; end
        end
        check("stuck valid cycle ch0", 32'(n), 32'd513);
        repeat (300) step(4'b0010);
        check("stuck flags", 32'({stuck, period_err}), 32'h0F0);
        check("stuck duties", 32'({duty0, duty1, duty2, duty3}), 32'h00FF0000);
        repeat (5) step(4'h0);
        drive_period(128, 256, -1);
        check("stuck held until publish", 32'(stuck), 32'hF);
        push_all(8'h80, 1'b0, 1'b0);
        drive_period(128, 256, -1);
        push_all(8'h80, 1'b0, 1'b0);
        close_and_check("stuck recovery");

        // Reset mid-period: outputs clear at once, first period after release not published.
        do_reset(4'h0);
        drive_period(128, 256, -1); push_all(8'h80, 1'b0, 1'b0);
        drive_period(128, 256, -1); push_all(8'h80, 1'b0, 1'b0);
        repeat (50) step(4'hF);
        check("pre-reset duty0", 32'(duty0), 32'h80);
        #2 reset = 1'b0;
        #1 check("async reset outputs", 32'({duty0, duty1, duty2, duty3, valid, stuck, period_err}), 32'd0);
        for (int c = 0; c < 4; c++) sb[c].delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) step(4'h0);
        drive_period(128, 256, -1); push_all(8'h80, 1'b0, 1'b0);
        drive_period(128, 256, -1); push_all(8'h80, 1'b0, 1'b0);
        close_and_check("after reset");

        // clk_en toggling every clk: measurement in ticks is unchanged.
        do_reset(4'h0);
        toggle_en = 1'b1;
        drive_period(128, 256, -1); push_all(8'h80, 1'b0, 1'b0);
        drive_period(128, 256, -1); push_all(8'h80, 1'b0, 1'b0);
        close_and_check("clk_en toggle");
        toggle_en = 1'b0;

        // One-tick glitch inside the low phase of the second period.
        do_reset(4'h0);
        drive_period(128, 256, -1); push_all(8'h80, 1'b0, 1'b0);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        drive_period(128, 256, 200); push_all(8'h80, 1'b0, 1'b0);
`else
        push_all(8'h80, 1'b1, 1'b0);
        drive_period(128, 256, 200); push_all(8'h01, 1'b1, 1'b0);
`endif
        drive_period(128, 256, -1); push_all(8'h80, 1'b0, 1'b0);
        close_and_check("glitch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
